// File: rtl/me_window_loader.sv
// Search-window / reference-block loader ahead of the motion estimator: writes the raster stream
// into search_memory and ref_memory, then holds start_signal until process_completed. Optional RUN timeout: ME_LOADER_TIMEOUT_EN.
`timescale 1ns/1ps
module me_window_loader #(
  parameter int PIX_W    = 8,
  parameter int REF_DIM  = 16,
  parameter int SRCH_DIM = 32,
  parameter int TIMEOUT  = 4200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_last,
  output logic             search_wr_en,
  output logic [9:0]       search_wr_addr,
  output logic             ref_wr_en,
  output logic [7:0]       ref_wr_addr,
  output logic [PIX_W-1:0] wr_data,
  output logic             start_signal,
  input  logic             process_completed,
  output logic             busy,
  output logic             block_done,
  output logic             framing_err,
  output logic             timeout_err
);

  localparam int SRCH_N = SRCH_DIM * SRCH_DIM;
  localparam int REF_N  = REF_DIM * REF_DIM;
  localparam logic [10:0] SRCH_LAST  = 11'(SRCH_N - 1);
  localparam logic [10:0] BLOCK_LAST = 11'(SRCH_N + REF_N - 1);
  localparam logic [10:0] REF_BASE   = 11'(SRCH_N);

  localparam logic [1:0] LOAD_SRCH = 2'd0;
  localparam logic [1:0] LOAD_REF  = 2'd1;
  localparam logic [1:0] RUN       = 2'd2;
  localparam logic [1:0] DONE      = 2'd3;

  logic [1:0]  state;
  logic [10:0] beat_cnt;
  logic        accept;
  logic        at_last;
  logic        early_last;
  logic        write_beat;
  logic        run_exit;
  logic        run_expired;

  assign pix_ready  = (state == LOAD_SRCH) || (state == LOAD_REF);
  assign accept     = pix_valid & pix_ready;
  assign at_last    = (beat_cnt == BLOCK_LAST);
  // A pix_last anywhere but the final beat is dropped rather than written.
  assign early_last = accept & pix_last & ~at_last;
  assign write_beat = accept & ~early_last;
  assign busy       = !((state == LOAD_SRCH) && (beat_cnt == '0));
  assign block_done = (state == DONE);

`ifdef ME_LOADER_TIMEOUT_EN
  logic [12:0] run_cnt;

  assign run_expired = (state == RUN) && (run_cnt == 13'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      run_cnt <= (state == RUN) ? run_cnt + 13'd1 : '0;
      if (run_expired && !process_completed) timeout_err <= 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign run_expired    = 1'b0;
  assign timeout_err    = 1'b0;
  assign unused_timeout = ^13'(TIMEOUT);
`endif

  assign run_exit = process_completed | run_expired;

  // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the write datapath is reset too, so no stale address or data is visible during reset.
      search_wr_en   <= 1'b0;
      ref_wr_en      <= 1'b0;
      search_wr_addr <= '0;
      ref_wr_addr    <= '0;
      wr_data        <= '0;
    end else begin
      search_wr_en <= write_beat & (state == LOAD_SRCH);
      ref_wr_en    <= write_beat & (state == LOAD_REF);
      if (write_beat) begin
        search_wr_addr <= beat_cnt[9:0];
        ref_wr_addr    <= 8'(beat_cnt - REF_BASE);
        wr_data        <= pix_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= LOAD_SRCH;
      beat_cnt     <= '0;
      start_signal <= 1'b0;
      framing_err  <= 1'b0;
    end else begin
      case (state)
        LOAD_SRCH, LOAD_REF: begin
          if (early_last) begin
            framing_err <= 1'b1;
            beat_cnt    <= '0;
            state       <= LOAD_SRCH;
          end else if (accept) begin
            if (at_last) begin
              if (!pix_last) framing_err <= 1'b1;
              state <= RUN;
            end else begin
              beat_cnt <= beat_cnt + 11'd1;
              if (beat_cnt == SRCH_LAST) state <= LOAD_REF;
            end
          end
        end
        RUN: begin
          // start rises one cycle into RUN, after the final reference write has landed.
          start_signal <= 1'b1;
          if (run_exit) begin
            start_signal <= 1'b0;
            state        <= DONE;
          end
        end
        DONE: begin
          beat_cnt <= '0;
          state    <= LOAD_SRCH;
        end
        default: state <= LOAD_SRCH;
      endcase
    end
  end

endmodule
